// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART transmitter and, later, the receiver.
package uart_pkg;

    // Payload width of one UART character.
    localparam int UART_DATA_BITS = 8;

    // Width of the data-bit index (counts UART_DATA_BITS-1 down to 0).
    localparam int UART_BIT_IDX_W = $clog2(UART_DATA_BITS);

    // Transmitter frame phases. PARITY is only reachable when UART_TX_PARITY_EN is defined.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    // Even parity bit: 1 when the byte holds an odd number of ones.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running bit-period counter in the system clock domain.
// Counts 0..CYCLES_PER_BIT-1 and raises tick during the last cycle of each bit
// period. clear restarts the period so a frame can align to its accept cycle.
// Written to be shared with the UART receiver.
module uart_baud_tick #(
    parameter int CYCLES_PER_BIT = 5208
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CYCLES_PER_BIT + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CYCLES_PER_BIT - 1);

    // A bit period shorter than one clock cycle cannot be represented.
    generate
        if (CYCLES_PER_BIT < 1) begin : g_bad_cycles_per_bit
            $error("uart_baud_tick: CYCLES_PER_BIT must be >= 1");
        end
    endgenerate

    logic [CNT_W-1:0] r_count;

    // Bit-period counter: restart on clear or at the end of each period.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear || (r_count == LAST_COUNT)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = (r_count == LAST_COUNT);

endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: serialises one byte per valid/ready handshake onto a UART line.
// Frame: start(0), 8 data bits MSB first, optional even parity, stop(1); idle line is 1.
// Build option: define UART_TX_PARITY_EN to insert the even-parity bit (11-bit frame);
// leave it undefined for a 10-bit frame with no parity logic at all.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ     = 50000000,
    parameter int BAUD_RATE      = 9600,
    parameter int CYCLES_PER_BIT = CLOCK_FREQ / BAUD_RATE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic                      tx,
    output logic                      busy,
    output logic                      tx_done
);

    localparam logic [UART_BIT_IDX_W-1:0] MSB_IDX = UART_BIT_IDX_W'(UART_DATA_BITS - 1);

    uart_tx_state_t              r_state;
    uart_tx_state_t              w_state_next;
    logic [UART_DATA_BITS-1:0]   r_shift;
    logic [UART_DATA_BITS-1:0]   w_shift_next;
    logic [UART_BIT_IDX_W-1:0]   r_bit_idx;
    logic [UART_BIT_IDX_W-1:0]   w_bit_idx_next;
    logic                        r_tx;
    logic                        w_tx_next;
    logic                        r_tx_done;
    logic                        w_tx_done_next;
`ifdef UART_TX_PARITY_EN
    logic                        r_parity;
    logic                        w_parity_next;
`endif

    logic w_accept;
    logic w_tick;

    // Handshake: only an idle, enabled transmitter takes a byte.
    assign tx_ready = (r_state == IDLE) & enable;
    assign w_accept = tx_valid & tx_ready;

    // Bit timing restarts on accept so the start bit gets a full period.
    uart_baud_tick #(
        .CYCLES_PER_BIT (CYCLES_PER_BIT)
    ) u_baud_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (w_accept),
        .tick  (w_tick)
    );

    // Frame register bank: state, shifter, bit index, registered line and done pulse.
    // NOTE: the shift register is reset too, so a reset mid-frame leaves no stale byte behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= MSB_IDX;
            r_tx      <= 1'b1;
            r_tx_done <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_idx <= w_bit_idx_next;
            r_tx      <= w_tx_next;
            r_tx_done <= w_tx_done_next;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity bit captured alongside the byte on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= w_parity_next;
        end
    end
`endif

    // Next-state logic; the line level is computed one cycle ahead so tx comes straight from a flop.
    // NOTE: every output of this block gets a default first, otherwise untouched paths infer latches.
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_idx_next = r_bit_idx;
        w_tx_next      = r_tx;
        w_tx_done_next = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_next  = r_parity;
`endif

        case (r_state)
            IDLE: begin
                w_tx_next = 1'b1;
                if (w_accept) begin
                    w_state_next   = START;
                    w_shift_next   = tx_data;
                    w_bit_idx_next = MSB_IDX;
                    w_tx_next      = 1'b0;
`ifdef UART_TX_PARITY_EN
                    w_parity_next  = even_parity(tx_data);
`endif
                end
            end

            START: begin
                if (w_tick) begin
                    w_state_next = DATA;
                    w_tx_next    = r_shift[UART_DATA_BITS-1];
                end
            end

            DATA: begin
                if (w_tick) begin
                    // Index decrements every bit and wraps 0 -> 7 as the byte ends.
                    w_bit_idx_next = r_bit_idx - 1'b1;
                    if (r_bit_idx == '0) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = PARITY;
                        w_tx_next    = r_parity;
`else
                        w_state_next = STOP;
                        w_tx_next    = 1'b1;
`endif
                    end else begin
                        w_shift_next = r_shift << 1;
                        w_tx_next    = r_shift[UART_DATA_BITS-2];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    w_state_next = STOP;
                    w_tx_next    = 1'b1;
                end
            end
`endif

            STOP: begin
                w_tx_next = 1'b1;
                if (w_tick) begin
                    w_state_next   = IDLE;
                    w_tx_done_next = 1'b1;
                end
            end

            default: begin
                w_state_next = IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    assign tx      = r_tx;
    assign busy    = (r_state != IDLE);
    assign tx_done = r_tx_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: self-checking bench for uart_transmitter.
// CLOCK_FREQ=100, BAUD_RATE=10 -> 10 clk cycles per bit. The accept cycle is cycle 0.
// Frame length follows UART_TX_PARITY_EN, exactly as the design does.
module tb_uart_transmitter;

    localparam int CLOCK_FREQ = 100;
    localparam int BAUD_RATE  = 10;
    localparam int CPB        = CLOCK_FREQ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam bit PAR_EN     = 1'b1;
`else
    localparam int FRAME_BITS = 10;
    localparam bit PAR_EN     = 1'b0;
`endif
    localparam int FRAME = FRAME_BITS * CPB;

    typedef struct {
        logic [7:0] data;
        logic       parity;   // expected even-parity bit, worked out by hand
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_transmitter #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .busy     (busy),
        .tx_done  (tx_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference line level for cycle c (1..FRAME) of a frame carrying byte d.
    function automatic logic model_tx(input logic [7:0] d, input logic par, input int c);
        int slot;
        slot = (c - 1) / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return d[8 - slot];
        if (PAR_EN && slot == 9) return par;
        return 1'b1;
    endfunction

    // Checks cycles first_c..last_c relative to the last accept (cycle 0), sampling at negedge.
    task automatic check_cycles(input logic [7:0] d, input logic par, input int first_c,
                                input int last_c, input string tag);
        for (int c = first_c; c <= last_c; c++) begin
            @(negedge clk);
            if (c <= FRAME) begin
                check({tag, " tx"},    tx, model_tx(d, par, c));
                check({tag, " busy"},  busy, 1'b1);
                check({tag, " done"},  tx_done, 1'b0);
                check({tag, " ready"}, tx_ready, 1'b0);
            end else if (c == FRAME + 1) begin
                check({tag, " end tx"},    tx, 1'b1);
                check({tag, " end busy"},  busy, 1'b0);
                check({tag, " end done"},  tx_done, 1'b1);
                check({tag, " end ready"}, tx_ready, enable);
            end else begin
                check({tag, " idle tx"},    tx, 1'b1);
                check({tag, " idle busy"},  busy, 1'b0);
                check({tag, " idle done"},  tx_done, 1'b0);
                check({tag, " idle ready"}, tx_ready, enable);
            end
        end
    endtask

    // Called just after a negedge: presents a byte, confirms it is taken on the next edge,
    // then drives the post-accept inputs (which the design must ignore while busy).
    task automatic accept(input logic [7:0] d, input logic keep_valid, input logic [7:0] hold_data);
        tx_data  = d;
        tx_valid = 1'b1;
        #1;
        check("accept ready", tx_ready, 1'b1);
        @(posedge clk);
        #1;
        tx_valid = keep_valid;
        tx_data  = hold_data;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run still active at %0t, expected to finish earlier", $time);
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        logic [7:0] d;
        logic       par;
        int         gap;

        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'h00, 1'b0};
        vecs[3] = '{8'hFF, 1'b0};
        vecs[4] = '{8'h01, 1'b1};
        vecs[5] = '{8'h80, 1'b1};
        vecs[6] = '{8'h6E, 1'b1};

        // Reset state, held across several edges with a byte offered.
        rst = 1'b1; enable = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        #1;
        check("reset tx", tx, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset done", tx_done, 1'b0);
        check("reset ready", tx_ready, 1'b1);
        tx_valid = 1'b1; tx_data = 8'h5A;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset hold tx", tx, 1'b1);
        check("reset hold busy", busy, 1'b0);
        check("reset hold done", tx_done, 1'b0);
        tx_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Table of known bytes with hand-derived parity.
        for (int i = 0; i < 7; i++) begin
            accept(vecs[i].data, 1'b0, ~vecs[i].data);
            check_cycles(vecs[i].data, vecs[i].parity, 1, FRAME + 2, "table");
        end

        // Back-to-back: valid held, data changed mid-frame, second accept on the done cycle.
        accept(8'h00, 1'b1, 8'hFF);
        check_cycles(8'h00, 1'b0, 1, FRAME + 1, "b2b first");
        check("b2b second accept ready", tx_ready, 1'b1);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        check_cycles(8'hFF, 1'b0, 1, FRAME + 2, "b2b second");

        // Reset during the data bits: line returns high before any clock edge.
        accept(8'hA5, 1'b0, 8'h00);
        check_cycles(8'hA5, 1'b0, 1, 45, "pre-reset");
        rst = 1'b1;
        #1;
        check("midreset tx", tx, 1'b1);
        check("midreset busy", busy, 1'b0);
        check("midreset done", tx_done, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midreset hold tx", tx, 1'b1);
            check("midreset hold done", tx_done, 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post-reset done", tx_done, 1'b0);
        accept(8'h3C, 1'b0, 8'hC3);
        check_cycles(8'h3C, 1'b0, 1, FRAME + 2, "post-reset 3C");

        // Enable dropped at cycle 30: frame completes, then no accept until enable returns.
        accept(8'hA5, 1'b0, 8'h00);
        check_cycles(8'hA5, 1'b0, 1, 30, "en-drop");
        enable = 1'b0;
        check_cycles(8'hA5, 1'b0, 31, FRAME + 1, "en-drop");
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        check_cycles(8'hA5, 1'b0, FRAME + 2, FRAME + 6, "en-low held");
        enable = 1'b1;
        accept(8'h5A, 1'b0, 8'h00);
        check_cycles(8'h5A, 1'b0, 1, FRAME + 2, "en-return 5A");

        // Random bytes with random idle gaps (gap 0 makes back-to-back frames).
        for (int i = 0; i < 25; i++) begin
            d   = 8'($urandom_range(0, 255));
            par = (($countones(d) % 2) == 1);
            gap = $urandom_range(0, 3);
            accept(d, 1'b0, 8'($urandom));
            check_cycles(d, par, 1, FRAME + 1 + gap, "random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
